// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Serialises one byte per valid/ready
//             handshake as: start bit, 8 data bits LSB first, optional
//             parity bit, 1 or 2 stop bits. Each bit lasts CLKS_PER_BIT
//             sys_clk cycles.
//  Ports    : sys_clk   - system clock, rising edge
//             reset_n   - asynchronous active-low reset
//             tx_data   - byte to send, sampled on acceptance only
//             tx_valid  - client presents a byte
//             tx_ready  - block is idle and accepts a byte this cycle
//             tx        - serial line, idles high, driven from a flop
//             tx_busy   - frame in progress
//             tx_done   - one-cycle pulse in the last stop-bit cycle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,   // 2..65535
    parameter int PARITY       = 0,    // 0 none, 1 even, 2 odd
    parameter int STOP_BITS    = 1     // 1 or 2
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int               C_CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             C_HAS_PARITY = (PARITY != 0);
    localparam logic             C_ODD_PARITY = (PARITY == 2);
    localparam logic             C_STOP_LAST  = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_shift;
    logic               r_par;
    logic               r_tx;

    logic w_bit_end;
    logic w_accept;
    logic w_tx_d;
    logic w_ready;
    logic w_done;

    assign w_bit_end = (r_cnt == C_CNT_MAX);
    assign w_accept  = (r_state == S_IDLE) && tx_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7))
                    w_state_nxt = C_HAS_PARITY ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end && (r_stop_idx == C_STOP_LAST)) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode from the registered state only.
    // w_tx_d is the line level for the current state; it is registered
    // into r_tx, so the pin lags the state by exactly one cycle and the
    // start bit appears on the edge after acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_d  = 1'b1;
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:   w_ready = 1'b1;
            S_START:  w_tx_d  = 1'b0;
            S_DATA:   w_tx_d  = r_shift[0];
            S_PARITY: w_tx_d  = r_par;
            S_STOP:   w_done  = w_bit_end && (r_stop_idx == C_STOP_LAST);
            default:  w_tx_d  = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: bit-period counter, bit/stop indices, shift register,
    // parity bit and the output flop.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_d;
            if (r_state == S_IDLE) begin
                r_cnt      <= '0;
                r_bit_idx  <= 3'd0;
                r_stop_idx <= 1'b0;
                if (w_accept) begin
                    r_shift <= tx_data;
                    // Parity is fixed at acceptance so later tx_data
                    // changes cannot disturb the frame.
                    r_par   <= C_ODD_PARITY ? ~^tx_data : ^tx_data;
                end
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    case (r_state)
                        S_DATA: begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                        S_STOP: begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign tx       = r_tx;
    assign tx_ready = w_ready;
    assign tx_busy  = ~w_ready;
    assign tx_done  = w_done;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one 8-bit byte per transaction onto a single asynchronous line as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits. Bit period is a fixed number of sys_clk cycles, with a default of 16 so that it matches the team's UART receiver, which samples every 16 system clocks. The block sits between a byte-producing client (valid/ready handshake) and the TX pin, and forms the transmit half of the UART module.

## Interface
- CLKS_PER_BIT, 16, sys_clk cycles per serial bit; legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

- sys_clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_valid  input  1  client has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is being transmitted.
- tx_done  output  1  one-cycle pulse at the end of a frame.

## Operation
- Reset: state IDLE; tx=1, tx_ready=1, tx_busy=0, tx_done=0; bit-period counter, bit index and shift register cleared.
- Acceptance: on a rising edge with tx_valid=1 and tx_ready=1, tx_data is latched into the internal shift register. If PARITY≠0, the parity bit is computed from the latched byte at the same edge. Later changes on tx_data have no effect on the frame in progress.
- State machine, with every state lasting exactly CLKS_PER_BIT cycles unless noted:
  - IDLE: tx=1, tx_ready=1. On acceptance, go to START.
  - START: tx=0. Then go to DATA with bit index 0.
  - DATA: tx = shift_reg[0]. At the end of each bit period, shift right and increment the bit index. After index 7, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: tx = ^byte for even parity, ~^byte for odd parity. Then go to STOP.
  - STOP: tx=1 for STOP_BITS × CLKS_PER_BIT cycles. tx_done=1 in the last cycle. Then go to IDLE.
- tx_ready = (state==IDLE). tx_busy = ~tx_ready. Both are registered, or decoded directly from the registered state with no combinational path from inputs.
- tx is driven from a flop, so the output is glitch-free.
- tx_valid outside IDLE is ignored. The block does not queue; the client holds tx_valid until it sees tx_ready.
- Bit-period counter width is clog2(CLKS_PER_BIT). The counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at the end of every bit; a wrap marks the bit boundary.
- Illegal or unreachable state encodings go to IDLE with tx=1.

## Timing
- Acceptance edge N: tx falls at edge N+1, which is the first START cycle.
- Frame length from first start cycle to last stop cycle is (1+8+(PARITY?1:0)+STOP_BITS) × CLKS_PER_BIT cycles. With defaults this is 160 cycles.
- tx_done is high in the final stop-bit cycle. tx_ready rises at the next edge.
- Back-to-back: a client holding tx_valid high gets the next byte accepted in the first IDLE cycle. The start bit follows one cycle later, so the gap between frames is exactly 1 extra high cycle beyond the stop bits.
- Reset mid-frame: tx goes to 1 and tx_ready to 1 asynchronously with reset_n. The partial frame is abandoned and no tx_done is generated. Operation resumes normally on the first edge after reset_n deasserts.
- Simultaneous tx_valid and reset release: no acceptance on the edge where reset_n is low. Acceptance is possible from the first edge with reset_n high.

## Test plan
- Defaults, send 0xA5: tx low for 16 cycles, then data 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. tx_done pulses at cycle 160 after the start edge. tx_ready is 0 throughout the frame.
- PARITY=1, 0xA5 (four ones): parity bit 0. PARITY=2, 0xA5: parity bit 1. PARITY=1, 0x07: parity bit 1. Frame length 176 cycles.
- STOP_BITS=2, CLKS_PER_BIT=4, send 0x3C: stop high for 8 cycles, frame length 44 cycles. tx_data changed to 0xFF mid-frame has no effect on tx.
- Back-to-back 0x00 then 0xFF with tx_valid held high: second start bit begins exactly 17 cycles after the first frame's stop bit began (defaults). tx_valid pulsed during the first frame is ignored.
- reset_n asserted in the middle of data bit 3: tx=1 immediately, tx_ready=1, no tx_done. A subsequent 0x5A is transmitted correctly.
- Loopback of tx into the UART receiver at defaults with bytes 0x00, 0x55, 0xAA, 0xFF: each byte is recovered with data_ready asserted once per frame.
